// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encodings,
// frame geometry and small helper functions.
package imem_boot_loader_pkg;

  localparam logic [2:0] LDR_IDLE = 3'd0;
  localparam logic [2:0] LDR_HDR0 = 3'd1;
  localparam logic [2:0] LDR_HDR1 = 3'd2;
  localparam logic [2:0] LDR_DATA = 3'd3;
  localparam logic [2:0] LDR_CSUM = 3'd4;
  localparam logic [2:0] LDR_DONE = 3'd5;
  localparam logic [2:0] LDR_ERR  = 3'd6;

  localparam int LDR_WORD_BYTES = 4;

  // Frame-owning states: the loader holds imem and accepts bytes.
  function automatic logic is_active(input logic [2:0] st);
    return (st == LDR_HDR0) || (st == LDR_HDR1) || (st == LDR_DATA) || (st == LDR_CSUM);
  endfunction

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/ldr_byte_packer.sv
// Assembles data bytes into little-endian 32-bit words, pulses word_valid for
// one cycle per completed word and keeps the running XOR checksum.
module ldr_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_end,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  localparam logic [1:0] LAST_IDX = 2'(LDR_WORD_BYTES - 1);

  logic [1:0]  idx_r;
  logic [23:0] shift_r;
  logic [31:0] word_r;
  logic        word_valid_r;
  logic [7:0]  csum_r;

  assign word_end   = (idx_r == LAST_IDX);
  assign word_valid = word_valid_r;
  assign word       = word_r;
  assign csum       = csum_r;

  // Byte index, shift/assemble, write pulse and checksum; word_r holds between words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r        <= 2'd0;
      shift_r      <= 24'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
      csum_r       <= 8'd0;
    end else if (clear) begin
      idx_r        <= 2'd0;
      shift_r      <= 24'd0;
      word_valid_r <= 1'b0;
      csum_r       <= 8'd0;
    end else begin
      word_valid_r <= byte_en && word_end;
      if (byte_en) begin
        csum_r <= xor_fold(csum_r, byte_in);
        idx_r  <= idx_r + 2'd1;
        if (word_end) begin
          word_r <= {byte_in, shift_r};
        end else begin
          shift_r <= {byte_in, shift_r[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Fills instruction memory from a framed byte stream (count, words, XOR csum)
// while holding the core frozen via load.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     DEPTH   = 17'(2 ** ADDR_W);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [15:0]       n_r;
  logic [TO_W-1:0]   idle_cnt_r;
  logic [ADDR_W:0]   words_r;
  logic [ADDR_W-1:0] addr_r;
  logic              in_ready_r;
  logic              load_r;
  logic              done_r;
  logic              err_r;

  logic        accept_s;
  logic        clear_s;
  logic        byte_en_s;
  logic        to_hit_s;
  logic        last_word_s;
  logic        word_end_s;
  logic [7:0]  csum_s;
  logic [15:0] hdr_n_s;

  assign accept_s    = in_valid && in_ready_r;
  assign clear_s     = start && ((state_r == LDR_IDLE) || (state_r == LDR_DONE) || (state_r == LDR_ERR));
  assign byte_en_s   = accept_s && (state_r == LDR_DATA);
  assign to_hit_s    = (idle_cnt_r == TO_LAST);
  assign hdr_n_s     = {in_data, n_r[7:0]};
  assign last_word_s = ((17'(words_r) + 17'd1) == {1'b0, n_r});

  ldr_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_s),
    .byte_en    (byte_en_s),
    .byte_in    (in_data),
    .word_end   (word_end_s),
    .word_valid (imem_we),
    .word       (imem_wdata),
    .csum       (csum_s)
  );

  // Next-state logic; an accepted byte always takes priority over the timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (clear_s) state_nxt_s = LDR_HDR0;
        else         state_nxt_s = state_r;
      end
      LDR_HDR0: begin
        if (accept_s)      state_nxt_s = LDR_HDR1;
        else if (to_hit_s) state_nxt_s = LDR_ERR;
        else               state_nxt_s = state_r;
      end
      LDR_HDR1: begin
        if (accept_s) begin
          if ({1'b0, hdr_n_s} > DEPTH) state_nxt_s = LDR_ERR;
          else if (hdr_n_s == 16'd0)   state_nxt_s = LDR_CSUM;
          else                         state_nxt_s = LDR_DATA;
        end else if (to_hit_s) begin
          state_nxt_s = LDR_ERR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      LDR_DATA: begin
        if (accept_s) begin
          if (word_end_s && last_word_s) state_nxt_s = LDR_CSUM;
          else                           state_nxt_s = LDR_DATA;
        end else if (to_hit_s) begin
          state_nxt_s = LDR_ERR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      LDR_CSUM: begin
        if (accept_s) begin
          if (in_data == csum_s) state_nxt_s = LDR_DONE;
          else                   state_nxt_s = LDR_ERR;
        end else if (to_hit_s) begin
          state_nxt_s = LDR_ERR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = LDR_IDLE;
    endcase
  end

  // State, status outputs (decoded from next state), header count, word counter, idle timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= LDR_IDLE;
      n_r        <= 16'd0;
      idle_cnt_r <= '0;
      words_r    <= '0;
      addr_r     <= '0;
      in_ready_r <= 1'b0;
      load_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= is_active(state_nxt_s);
      load_r     <= is_active(state_nxt_s);
      done_r     <= (state_nxt_s == LDR_DONE);
      err_r      <= (state_nxt_s == LDR_ERR);
      if (accept_s && (state_r == LDR_HDR0)) n_r[7:0]  <= in_data;
      if (accept_s && (state_r == LDR_HDR1)) n_r[15:8] <= in_data;
      if (clear_s) begin
        words_r <= '0;
      end else if (byte_en_s && word_end_s) begin
        words_r <= words_r + (ADDR_W + 1)'(1);
        addr_r  <= words_r[ADDR_W-1:0];
      end
      if (clear_s || accept_s || !is_active(state_r)) idle_cnt_r <= '0;
      else                                            idle_cnt_r <= idle_cnt_r + TO_W'(1);
    end
  end

  assign in_ready     = in_ready_r;
  assign load         = load_r;
  assign done         = done_r;
  assign err          = err_r;
  assign imem_addr    = addr_r;
  assign words_loaded = words_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: inputs change on the falling edge,
// outputs are checked on the falling edge after the accepting rising edge.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        load;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  logic [31:0] wr_data [0:255];
  logic [7:0]  last_addr;
  logic [7:0]  frame_q[$];

  imem_boot_loader #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .load(load), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_cnt++;
      wr_data[imem_addr] = imem_wdata;
      last_addr = imem_addr;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    total++; if ({in_ready, load, done, err, imem_we} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, load, done, err, imem_we}); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
    total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", imem_wdata); end
    total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  // N=2 frame at full rate; checks write latency and final status.
  task automatic test_two_words();
    int base;
    base = we_cnt;
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    pulse_start();
    total++; if ({load, in_ready} !== 2'b11) begin bad++; $display("FAIL n2_load_on got=%b exp=11", {load, in_ready}); end
    for (int i = 0; i < 11; i++) begin
      send_byte(frame_q[i]);
      if (i == 5) begin
        total++; if ({imem_we, imem_addr} !== {1'b1, 8'h00}) begin bad++; $display("FAIL n2_we0 got=%b/%h exp=1/00", imem_we, imem_addr); end
        total++; if (imem_wdata !== 32'h00500013) begin bad++; $display("FAIL n2_wdata0 got=%h exp=00500013", imem_wdata); end
        total++; if (words_loaded !== 9'd1) begin bad++; $display("FAIL n2_words1 got=%0d exp=1", words_loaded); end
      end
      if (i == 6) begin
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL n2_we_pulse got=%b exp=0", imem_we); end
      end
      if (i == 9) begin
        total++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h01, 32'h00100093}) begin bad++; $display("FAIL n2_we1 got=%b/%h/%h exp=1/01/00100093", imem_we, imem_addr, imem_wdata); end
        total++; if (load !== 1'b1) begin bad++; $display("FAIL n2_load_csum got=%b exp=1", load); end
      end
    end
    in_valid = 1'b0;
    total++; if ({done, err, load, in_ready} !== 4'b1000) begin bad++; $display("FAIL n2_status got=%b exp=1000", {done, err, load, in_ready}); end
    idle(3);
    total++; if (words_loaded !== 9'd2) begin bad++; $display("FAIL n2_words got=%0d exp=2", words_loaded); end
    total++; if (we_cnt - base !== 2) begin bad++; $display("FAIL n2_we_count got=%0d exp=2", we_cnt - base); end
    total++; if (imem_addr !== 8'h01) begin bad++; $display("FAIL n2_addr_hold got=%h exp=01", imem_addr); end
  endtask

  // From DONE, a new frame clears status; start mid-frame is ignored.
  task automatic test_restart_from_done();
    pulse_start();
    total++; if ({done, load, in_ready} !== 3'b011) begin bad++; $display("FAIL rs_hdr0 got=%b exp=011", {done, load, in_ready}); end
    total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL rs_words0 got=%0d exp=0", words_loaded); end
    frame_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    for (int i = 0; i < 7; i++) begin
      start = (i == 3) ? 1'b1 : 1'b0;
      send_byte(frame_q[i]);
    end
    start = 1'b0;
    in_valid = 1'b0;
    idle(2);
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL rs_done got=%b exp=10", {done, err}); end
    total++; if (wr_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rs_word got=%h exp=DEADBEEF", wr_data[0]); end
    total++; if (words_loaded !== 9'd1) begin bad++; $display("FAIL rs_words got=%0d exp=1", words_loaded); end
  endtask

  task automatic test_empty_frame();
    int base;
    base = we_cnt;
    frame_q = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame();
    total++; if ({done, err, load} !== 3'b100) begin bad++; $display("FAIL n0_ok got=%b exp=100", {done, err, load}); end
    frame_q = '{8'h00, 8'h00, 8'h01};
    pulse_start();
    send_frame();
    total++; if ({done, err, load} !== 3'b010) begin bad++; $display("FAIL n0_badcsum got=%b exp=010", {done, err, load}); end
    idle(2);
    total++; if (we_cnt - base !== 0) begin bad++; $display("FAIL n0_no_write got=%0d exp=0", we_cnt - base); end
  endtask

  task automatic test_oversize();
    int base;
    base = we_cnt;
    pulse_start();
    send_byte(8'h01);
    total++; if ({load, err} !== 2'b10) begin bad++; $display("FAIL ov_hdr0 got=%b exp=10", {load, err}); end
    send_byte(8'h01);
    in_valid = 1'b0;
    total++; if ({load, err, done, in_ready} !== 4'b0100) begin bad++; $display("FAIL ov_err got=%b exp=0100", {load, err, done, in_ready}); end
    idle(3);
    total++; if (we_cnt - base !== 0) begin bad++; $display("FAIL ov_no_write got=%0d exp=0", we_cnt - base); end
  endtask

  // Stall after 5 data bytes: byte on 16th idle cycle saves it, a full stall does not.
  task automatic test_timeout();
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93};
    pulse_start();
    send_frame();
    idle(15);
    total++; if ({err, load} !== 2'b01) begin bad++; $display("FAIL to_edge_rescue_pre got=%b exp=01", {err, load}); end
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'hC0);
    in_valid = 1'b0;
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL to_rescued got=%b exp=10", {done, err}); end
    pulse_start();
    send_frame();
    idle(15);
    total++; if ({err, load} !== 2'b01) begin bad++; $display("FAIL to_cycle15 got=%b exp=01", {err, load}); end
    idle(1);
    total++; if ({err, load, done} !== 3'b100) begin bad++; $display("FAIL to_cycle16 got=%b exp=100", {err, load, done}); end
  endtask

  task automatic test_reset_mid_frame();
    frame_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    pulse_start();
    send_frame();
    rst = 1'b0;
    #1;
    total++; if ({in_ready, load, done, err, imem_we} !== 5'b0) begin bad++; $display("FAIL mr_flags got=%b exp=00000", {in_ready, load, done, err, imem_we}); end
    total++; if ({imem_addr, imem_wdata, words_loaded} !== 49'd0) begin bad++; $display("FAIL mr_data got=%h/%h/%0d exp=0/0/0", imem_addr, imem_wdata, words_loaded); end
    idle(2);
    rst = 1'b1;
    idle(1);
    test_two_words();
  endtask

  // N equal to memory depth: last address all-ones, counter reaches 256 without wrapping.
  task automatic test_full_depth();
    int base;
    base = we_cnt;
    frame_q = {};
    frame_q.push_back(8'h00);
    frame_q.push_back(8'h01);
    for (int w = 0; w < 256; w++) begin
      frame_q.push_back(8'(w));
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h5A);
      frame_q.push_back(8'h00);
    end
    frame_q.push_back(8'h00);
    pulse_start();
    send_frame();
    idle(2);
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL fd_done got=%b exp=10", {done, err}); end
    total++; if (words_loaded !== 9'h100) begin bad++; $display("FAIL fd_words got=%h exp=100", words_loaded); end
    total++; if (last_addr !== 8'hFF) begin bad++; $display("FAIL fd_last_addr got=%h exp=FF", last_addr); end
    total++; if (wr_data[255] !== 32'h005A00FF) begin bad++; $display("FAIL fd_last_word got=%h exp=005A00FF", wr_data[255]); end
    total++; if (wr_data[128] !== 32'h005A0080) begin bad++; $display("FAIL fd_mid_word got=%h exp=005A0080", wr_data[128]); end
    total++; if (we_cnt - base !== 256) begin bad++; $display("FAIL fd_we_count got=%0d exp=256", we_cnt - base); end
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_two_words();
    test_restart_from_done();
    test_empty_frame();
    test_oversize();
    test_timeout();
    test_reset_mid_frame();
    test_full_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
